// File: rtl/cv32e40p_voter_monitor.sv
// Triple-replica majority voter with per-replica health tracking.
// Replicas that keep disagreeing are demoted to FAULTY and excluded from later votes.
module cv32e40p_voter_monitor #(
  parameter int WIDTH     = 32,
  parameter int ENTRIES   = 16,
  parameter int CNT_W     = 8,
  parameter int FAULT_THR = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            valid_i,
  input  logic [ENTRIES-1:0][WIDTH-1:0]   res1_i,
  input  logic [ENTRIES-1:0][WIDTH-1:0]   res2_i,
  input  logic [ENTRIES-1:0][WIDTH-1:0]   res3_i,
  input  logic                            clear_i,
  output logic [ENTRIES-1:0][WIDTH-1:0]   result_o,
  output logic                            valid_o,
  output logic [2:0]                      err_o,
  output logic                            uncorrectable_o,
  output logic [2:0]                      faulty_o,
  output logic                            degraded_o,
  output logic [2:0][CNT_W-1:0]           err_cnt_o
);

  typedef enum logic [1:0] {HEALTHY, SUSPECT, FAULTY} health_e;

  localparam int              N       = ENTRIES * WIDTH;
  localparam logic [3:0]      THR     = 4'(FAULT_THR);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N-1:0]     res [3];
  health_e          state_q [3];
  health_e          state_d [3];
  logic [3:0]       consec_q [3];
  logic [3:0]       consec_d [3];
  logic [CNT_W-1:0] err_cnt_q [3];
  logic [CNT_W-1:0] err_cnt_d [3];

  logic [N-1:0] result_q, result_d;
  logic         valid_q, valid_d;
  logic [2:0]   err_q, err_d;
  logic         unc_q, unc_d;

  logic [2:0]   active;
  logic [2:0]   vote_err;
  logic         attributed;
  logic         unc;
  logic [N-1:0] vote;
  logic [N-1:0] maj;
  logic [1:0]   lo_idx, hi_idx;

  assign res[0] = res1_i;
  assign res[1] = res2_i;
  assign res[2] = res3_i;

  always_comb begin
    for (int k = 0; k < 3; k++) active[k] = (state_q[k] != FAULTY);
    maj        = (res[0] & res[1]) | (res[0] & res[2]) | (res[1] & res[2]);
    vote       = res[0];
    vote_err   = '0;
    attributed = 1'b0;
    unc        = 1'b0;
    lo_idx     = active[0] ? 2'd0 : 2'd1;
    hi_idx     = active[2] ? 2'd2 : 2'd1;
    case (active)
      3'b111: begin
        vote       = maj;
        attributed = 1'b1;
        for (int k = 0; k < 3; k++) vote_err[k] = |(res[k] ^ maj);
      end
      3'b011, 3'b101, 3'b110: begin
        // Disagreement between two survivors cannot be blamed on either one
        vote = res[lo_idx];
        if (res[lo_idx] == res[hi_idx]) attributed = 1'b1;
        else                            unc        = 1'b1;
      end
      3'b010:  vote = res[1];
      3'b100:  vote = res[2];
      default: vote = res[0];
    endcase
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      state_d[k]   = state_q[k];
      consec_d[k]  = consec_q[k];
      err_cnt_d[k] = err_cnt_q[k];
      if (clear_i) begin
        state_d[k]   = HEALTHY;
        consec_d[k]  = '0;
        err_cnt_d[k] = '0;
      end else if (valid_i && attributed && active[k]) begin
        if (vote_err[k]) begin
          if (err_cnt_q[k] != CNT_MAX) err_cnt_d[k] = err_cnt_q[k] + 1'b1;
          if (state_q[k] == HEALTHY) begin
            consec_d[k] = 4'd1;
            state_d[k]  = (THR == 4'd1) ? FAULTY : SUSPECT;
          end else begin
            if (consec_q[k] != 4'hF) consec_d[k] = consec_q[k] + 4'd1;
            if (consec_q[k] >= THR - 4'd1) state_d[k] = FAULTY;
          end
        end else if (state_q[k] == SUSPECT) begin
          state_d[k]  = HEALTHY;
          consec_d[k] = '0;
        end
      end
    end
    // All three can miss a bitwise majority at once; keep replica 0 alive as the last voter
    if (!clear_i && state_d[0] == FAULTY && state_d[1] == FAULTY && state_d[2] == FAULTY)
      state_d[0] = SUSPECT;
  end

  always_comb begin
    result_d = valid_i ? vote : result_q;
    valid_d  = valid_i;
    err_d    = valid_i ? vote_err : 3'b000;
    unc_d    = valid_i & unc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        state_q[k]   <= HEALTHY;
        consec_q[k]  <= '0;
        err_cnt_q[k] <= '0;
      end
      result_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= '0;
      unc_q    <= 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        state_q[k]   <= state_d[k];
        consec_q[k]  <= consec_d[k];
        err_cnt_q[k] <= err_cnt_d[k];
      end
      result_q <= result_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      unc_q    <= unc_d;
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      faulty_o[k]  = (state_q[k] == FAULTY);
      err_cnt_o[k] = err_cnt_q[k];
    end
  end

  assign degraded_o      = (faulty_o == 3'b011) || (faulty_o == 3'b101) || (faulty_o == 3'b110);
  assign result_o        = result_q;
  assign valid_o         = valid_q;
  assign err_o           = err_q;
  assign uncorrectable_o = unc_q;

endmodule

// File: tb/tb_cv32e40p_voter_monitor.sv
// Directed bench for cv32e40p_voter_monitor at default parameters.
module tb_cv32e40p_voter_monitor;

  localparam int WIDTH   = 32;
  localparam int ENTRIES = 16;
  localparam int CNT_W   = 8;
  localparam int N       = WIDTH * ENTRIES;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic                          valid_i;
  logic                          clear_i;
  logic [ENTRIES-1:0][WIDTH-1:0] r1, r2, r3;
  logic [ENTRIES-1:0][WIDTH-1:0] result_o;
  logic                          valid_o;
  logic [2:0]                    err_o;
  logic                          uncorrectable_o;
  logic [2:0]                    faulty_o;
  logic                          degraded_o;
  logic [2:0][CNT_W-1:0]         err_cnt_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cv32e40p_voter_monitor #(.WIDTH(WIDTH), .ENTRIES(ENTRIES), .CNT_W(CNT_W), .FAULT_THR(4)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i),
    .res1_i(r1), .res2_i(r2), .res3_i(r3), .clear_i(clear_i),
    .result_o(result_o), .valid_o(valid_o), .err_o(err_o),
    .uncorrectable_o(uncorrectable_o), .faulty_o(faulty_o),
    .degraded_o(degraded_o), .err_cnt_o(err_cnt_o)
  );

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [N-1:0] fill(input logic [31:0] v);
    logic [N-1:0] f;
    for (int i = 0; i < ENTRIES; i++) f[i*32 +: 32] = v;
    return f;
  endfunction

  function automatic logic [N-1:0] flip(input logic [N-1:0] v, input int b);
    logic [N-1:0] f;
    f    = v;
    f[b] = ~f[b];
    return f;
  endfunction

  // Presents one vote, lets it be captured, then samples just after the edge
  task automatic vote(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] c,
                      input logic clr);
    r1 = a; r2 = b; r3 = c;
    valid_i = 1'b1;
    clear_i = clr;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    clear_i = 1'b0;
  endtask

  logic [N-1:0] A, E, F;
  logic         saw_valid;

  initial begin
    A = fill(32'hA5A5A5A5);
    E = fill(32'h12345678);
    F = fill(32'hDEADBEEF);
    rst_n = 1'b0; valid_i = 1'b0; clear_i = 1'b0;
    r1 = '0; r2 = '0; r3 = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", result_o, '0);
    chk("rst_valid", N'(valid_o), '0);
    chk("rst_err", N'(err_o), '0);
    chk("rst_faulty", N'(faulty_o), '0);
    chk("rst_degraded", N'(degraded_o), '0);
    chk("rst_cnt", N'(err_cnt_o), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // all agree
    vote(A, A, A, 1'b0);
    chk("agree_result", result_o, A);
    chk("agree_valid", N'(valid_o), 1);
    chk("agree_err", N'(err_o), 0);
    chk("agree_cnt", N'(err_cnt_o), '0);
    @(posedge clk); #1;
    chk("idle_valid", N'(valid_o), 0);
    chk("idle_hold", result_o, A);
    chk("idle_err", N'(err_o), 0);

    // single flipped bit in replica 1, entry 3
    vote(A, flip(A, 96), A, 1'b0);
    chk("r1err_result", result_o, A);
    chk("r1err_err", N'(err_o), 3'b010);
    chk("r1err_cnt1", N'(err_cnt_o[1]), 1);
    vote(A, A, A, 1'b0);
    chk("r1clean_result", result_o, A);
    chk("r1clean_err", N'(err_o), 0);
    chk("r1clean_cnt1", N'(err_cnt_o[1]), 1);

    // replica 2 corrupted four times in a row
    for (int i = 0; i < 4; i++) begin
      vote(A, A, flip(A, 500), 1'b0);
      chk("r2err_result", result_o, A);
      chk("r2err_err", N'(err_o), 3'b100);
      chk("r2err_faulty", N'(faulty_o), (i == 3) ? 3'b100 : 3'b000);
    end
    chk("r2err_cnt2", N'(err_cnt_o[2]), 4);
    vote(A, flip(A, 0), F, 1'b0);
    chk("unc_flag", N'(uncorrectable_o), 1);
    chk("unc_result", result_o, A);
    chk("unc_err", N'(err_o), 0);
    chk("unc_cnt", N'(err_cnt_o), {8'd4, 8'd1, 8'd0});
    chk("unc_degraded", N'(degraded_o), 0);
    vote(E, E, F, 1'b0);
    chk("two_agree_result", result_o, E);
    chk("two_agree_unc", N'(uncorrectable_o), 0);
    @(posedge clk); #1;
    chk("unc_idle", N'(uncorrectable_o), 0);

    // clear together with a vote
    vote(F, F, A, 1'b1);
    chk("clr_valid", N'(valid_o), 1);
    chk("clr_result", result_o, F);
    chk("clr_faulty", N'(faulty_o), 0);
    chk("clr_cnt", N'(err_cnt_o), '0);

    // replicas 1 and 2 fail together
    for (int i = 0; i < 4; i++) begin
      vote(A, flip(A, 5), flip(A, 77), 1'b0);
      chk("dual_result", result_o, A);
      chk("dual_err", N'(err_o), 3'b110);
      chk("dual_faulty", N'(faulty_o), (i == 3) ? 3'b110 : 3'b000);
    end
    chk("dual_degraded", N'(degraded_o), 1);
    chk("dual_cnt", N'(err_cnt_o), {8'd4, 8'd4, 8'd0});
    vote(F, E, A, 1'b0);
    chk("one_result", result_o, F);
    chk("one_err", N'(err_o), 0);
    chk("one_unc", N'(uncorrectable_o), 0);

    // clear alone, then put replica 2 into SUSPECT and reset with a vote in flight
    clear_i = 1'b1;
    @(posedge clk); #1;
    clear_i = 1'b0;
    chk("clr2_faulty", N'(faulty_o), 0);
    chk("clr2_degraded", N'(degraded_o), 0);
    vote(A, A, flip(A, 9), 1'b0);
    chk("sus_cnt2", N'(err_cnt_o[2]), 1);
    vote(E, E, E, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_result", result_o, '0);
    chk("arst_valid", N'(valid_o), 0);
    chk("arst_cnt", N'(err_cnt_o), '0);
    chk("arst_faulty", N'(faulty_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      saw_valid |= valid_o;
    end
    chk("arst_no_pulse", N'(saw_valid), 0);

    // counter saturation: alternating error / clean keeps replica 1 out of FAULTY
    for (int i = 0; i < 260; i++) begin
      vote(A, flip(A, i % N), A, 1'b0);
      vote(A, A, A, 1'b0);
    end
    chk("sat_cnt1", N'(err_cnt_o[1]), 255);
    chk("sat_faulty", N'(faulty_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
